// File: rtl/cmos_pixel_pack_pkg.sv
// Shared types and constants for the DVP capture path: FSM states, word-counter width,
// frame size helper and the RGB565 colour-bar palette used by the test pattern.
package cmos_pixel_pack_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_SKIP      = 2'd1,
        ST_WAIT_VS   = 2'd2,
        ST_CAPTURE   = 2'd3
    } state_e;

    localparam int WCNT_W = 17;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    function automatic int words_per_frame(input int h_pixels, input int v_lines);
        return (h_pixels * v_lines) / 2;
    endfunction

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/cmos_pixel_pack_if.sv
// DVP sensor bus in, frame-buffer write port out.
// master = sensor/driver side, slave = capture block.
interface cmos_pixel_pack_if;
    logic        cmos_vsync;
    logic        cmos_href;
    logic [7:0]  cmos_data;
    logic        sys_we;
    logic [31:0] sys_data_in;
    logic        data_valid_wr;
    logic        frame_switch;
    logic        frame_err;

    modport master (
        output cmos_vsync, cmos_href, cmos_data,
        input  sys_we, sys_data_in, data_valid_wr, frame_switch, frame_err
    );

    modport slave (
        input  cmos_vsync, cmos_href, cmos_data,
        output sys_we, sys_data_in, data_valid_wr, frame_switch, frame_err
    );
endinterface

// File: rtl/cmos_byte_packer.sv
// Registers the DVP bus once and packs 4 bytes into a 32-bit word (colour bars with CMOS_TEST_PATTERN_EN).
// Latency 2 clk from 4th byte to word_vld_o; no backpressure, a partial word is dropped on href fall.
module cmos_byte_packer
    import cmos_pixel_pack_pkg::*;
`ifdef CMOS_TEST_PATTERN_EN
    #(parameter int H_PIXELS = 480)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        vsync_i,
    input  logic        href_i,
    input  logic [7:0]  data_i,
    output logic        vs_rise_o,
    output logic        vs_fall_o,
    output logic        word_vld_o,
    output logic [31:0] word_o
);

    logic        vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d;
    logic        hr_s1_q, hr_s1_d;
    logic [7:0]  dat_s1_q, dat_s1_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] acc_q, acc_d;
    logic        word_vld_q, word_vld_d;
    logic [31:0] word_q, word_d;

`ifdef CMOS_TEST_PATTERN_EN
    localparam int COL_W = $clog2(H_PIXELS) + 1;
    localparam int BAR_W = (H_PIXELS >= 8) ? H_PIXELS / 8 : 1;
    logic [COL_W-1:0] col_q, col_d;

    function automatic logic [15:0] bar_px(input logic [COL_W-1:0] c);
        int b;
        b = int'(c) / BAR_W;
        if (b > 7) b = 7;
        return bar_color(3'(b));
    endfunction
`endif

    always_comb begin
        vs_s1_d    = vsync_i;
        hr_s1_d    = href_i;
        dat_s1_d   = data_i;
        vs_s2_d    = vs_s1_q;
        cnt_d      = 2'd0;
        acc_d      = acc_q;
        word_vld_d = 1'b0;
        word_d     = word_q;
`ifdef CMOS_TEST_PATTERN_EN
        col_d = hr_s1_q ? col_q : '0;
`endif
        // vsync overrides href: bytes seen with vsync high never reach a word
        if (en_i && hr_s1_q && !vs_s1_q) begin
            cnt_d = cnt_q + 2'd1;
            acc_d = {acc_q[15:0], dat_s1_q};
            if (cnt_q == 2'd3) begin
                word_vld_d = 1'b1;
`ifdef CMOS_TEST_PATTERN_EN
                word_d = {bar_px(col_q), bar_px(col_q + COL_W'(1))};
                col_d  = col_q + COL_W'(2);
`else
                word_d = {acc_q, dat_s1_q};
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_s1_q    <= 1'b0;
            vs_s2_q    <= 1'b0;
            hr_s1_q    <= 1'b0;
            dat_s1_q   <= 8'd0;
            cnt_q      <= 2'd0;
            acc_q      <= 24'd0;
            word_vld_q <= 1'b0;
            word_q     <= 32'd0;
`ifdef CMOS_TEST_PATTERN_EN
            col_q      <= '0;
`endif
        end else begin
            vs_s1_q    <= vs_s1_d;
            vs_s2_q    <= vs_s2_d;
            hr_s1_q    <= hr_s1_d;
            dat_s1_q   <= dat_s1_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            word_vld_q <= word_vld_d;
            word_q     <= word_d;
`ifdef CMOS_TEST_PATTERN_EN
            col_q      <= col_d;
`endif
        end
    end

    assign vs_rise_o  = vs_s1_q & ~vs_s2_q;
    assign vs_fall_o  = ~vs_s1_q & vs_s2_q;
    assign word_vld_o = word_vld_q;
    assign word_o     = word_q;

endmodule

// File: rtl/cmos_pixel_pack.sv
// OV5640 RGB565 capture into 2-pixel words for the frame buffer; CMOS_TEST_PATTERN_EN swaps in colour bars.
// Latency 2 clk from 4th byte to sys_we; no backpressure (sensor cannot be stalled).
module cmos_pixel_pack
    import cmos_pixel_pack_pkg::*;
#(
    parameter int FRAME_SKIP = 10,
    parameter int H_PIXELS   = 480,
    parameter int V_LINES    = 272
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ddr_init_done,
    cmos_pixel_pack_if.slave  bus
);

    localparam logic [WCNT_W-1:0] WPF = WCNT_W'(words_per_frame(H_PIXELS, V_LINES));
    localparam int SKIP_W = (FRAME_SKIP > 1) ? $clog2(FRAME_SKIP) : 1;
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((FRAME_SKIP > 0) ? FRAME_SKIP - 1 : 0);

    state_e             state_q, state_d;
    logic [SKIP_W-1:0]  skip_q, skip_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d, wcnt_sum;
    logic               dv_q, dv_d, fs_q, fs_d, err_q, err_d;
    logic               en, vs_rise, vs_fall, word_vld;
    logic [31:0]        word;

    assign en = (state_q == ST_CAPTURE) && ddr_init_done;

    cmos_byte_packer
`ifdef CMOS_TEST_PATTERN_EN
        #(.H_PIXELS(H_PIXELS))
`endif
    u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en),
        .vsync_i    (bus.cmos_vsync),
        .href_i     (bus.cmos_href),
        .data_i     (bus.cmos_data),
        .vs_rise_o  (vs_rise),
        .vs_fall_o  (vs_fall),
        .word_vld_o (word_vld),
        .word_o     (word)
    );

    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        dv_d     = dv_q;
        fs_d     = 1'b0;
        err_d    = err_q;
        // the last word's strobe can coincide with vs_rise, so the frame check uses the updated count
        wcnt_sum = wcnt_q;
        if (word_vld && (wcnt_q != '1)) wcnt_sum = wcnt_q + WCNT_W'(1);
        wcnt_d = vs_fall ? '0 : wcnt_sum;
        case (state_q)
            ST_WAIT_INIT: begin
                if (ddr_init_done) begin
                    state_d = ST_SKIP;
                    skip_d  = '0;
                end
            end
            ST_SKIP: begin
                if (FRAME_SKIP == 0) begin
                    state_d = ST_WAIT_VS;
                end else if (vs_rise) begin
                    if (skip_q == SKIP_LAST) state_d = ST_WAIT_VS;
                    else                     skip_d  = skip_q + SKIP_W'(1);
                end
            end
            ST_WAIT_VS: begin
                if (vs_fall) begin
                    state_d = ST_CAPTURE;
                    dv_d    = 1'b1;
                end
            end
            default: begin
                if (vs_fall) dv_d = 1'b1;
                if (vs_rise) begin
                    dv_d = 1'b0;
                    if (dv_q) begin
                        if (wcnt_sum == WPF) fs_d  = 1'b1;
                        else                 err_d = 1'b1;
                    end
                end
            end
        endcase
        if (!ddr_init_done) begin
            state_d = ST_WAIT_INIT;
            dv_d    = 1'b0;
            fs_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_INIT;
            skip_q  <= '0;
            wcnt_q  <= '0;
            dv_q    <= 1'b0;
            fs_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            wcnt_q  <= wcnt_d;
            dv_q    <= dv_d;
            fs_q    <= fs_d;
            err_q   <= err_d;
        end
    end

    assign bus.sys_we        = word_vld;
    assign bus.sys_data_in   = word;
    assign bus.data_valid_wr = dv_q;
    assign bus.frame_switch  = fs_q;
    assign bus.frame_err     = err_q;

endmodule
